letc_core_stage_fetch2: RTL and testbench
=========================================

// Module: letc_core_stage_fetch2
// PURPOSE
//  2nd fetch stage. Pairs each PC delivered by fetch 1 with its in-order IMSS instruction response.
//  Holds the PC/instruction pair until decode consumes it and discards responses orphaned by a flush.
//  Sits between fetch 1 (upstream) and decode (downstream); stalls and flushes come from adhesive.
// PARAMETERS
//  PC_W        32  PC / virtual address width
//  INSTR_W     32  instruction width
//  MAX_DROP    2   max orphaned IMSS responses outstanding after flushes; DROP_W = $clog2(MAX_DROP+1)
// PORTS
//  clk             in   1        clock
//  rst_n           in   1        asynchronous active-low reset
//  f2_ready        out  1        f2 can accept a PC this cycle (to adhesive)
//  f2_flush        in   1        discard held/pending contents
//  f2_stall        in   1        hold outputs; decode not consuming
//  f1_to_f2_valid  in   1        fetch 1 PC valid
//  f1_to_f2_pc     in   PC_W     fetch 1 PC
//  imss_rsp_valid  in   1        IMSS instruction response valid; no backpressure, in order
//  imss_rsp_instr  in   INSTR_W  fetched instruction
//  imss_rsp_fault  in   1        access/page fault on this fetch
//  f2_to_d_valid   out  1        pair valid to decode
//  f2_to_d_pc      out  PC_W     PC of the instruction
//  f2_to_d_instr   out  INSTR_W  instruction; 0 when either fault is set
//  f2_to_d_fault   out  1        IMSS fault
//  f2_to_d_misalign out 1        f2_to_d_pc[1:0] != 0
// BEHAVIOUR
//  Reset (async, rst_n low): state=EMPTY, drop_cnt=0, pc/instr regs=0. All outputs 0 except f2_ready=1.
//  Response contract: one response per accepted PC, arriving strictly after the capture edge, in order.
//  States:
//   EMPTY: f1_to_f2_valid & !f2_flush -> capture pc, go WAIT.
//   WAIT: usable response (imss_rsp_valid & drop_cnt==0) -> latch instr/fault, go READY. Latch even when stalled.
//   READY: f2_to_d_valid=1. Consumed when !f2_stall.
//    - Consumed with f1_to_f2_valid -> capture new pc, go WAIT.
//    - Consumed without f1_to_f2_valid -> go EMPTY.
//    - Stalled -> hold all outputs stable.
//  f2_ready = (state != WAIT); registered-state-only, no combinational path from any input.
//  f2_to_d_valid = (state==READY) & !f2_flush. Decode sees an instruction 1 cycle after its response edge.
//  Throughput: one instr per 2 cycles with 1-cycle IMSS latency.
//  Drop counter:
//   - While drop_cnt>0, each imss_rsp_valid is discarded and drop_cnt decrements; state unaffected.
//   - Flush in WAIT: drop_cnt increments; if a response arrives that same cycle it is the pending one,
//     so it is dropped and drop_cnt stays unchanged (net 0).
//   - Simultaneous decrement and increment: net unchanged.
//  Flush (highest priority over stall and capture): state -> EMPTY; f1_to_f2_valid that cycle is ignored.
//  f2_to_d_instr = fault|misalign ? 0 : latched instr. Misalign is computed from the held pc.
//  Simulation-only assertions:
//   - f1_to_f2_valid only in EMPTY or in a READY-and-consumed cycle.
//   - drop_cnt never exceeds MAX_DROP.
//   - No imss_rsp_valid in EMPTY/READY while drop_cnt==0.
//   - No simultaneous f2_flush & f2_stall.
//   - Outputs $stable while READY & f2_stall.
//  Reset mid-operation: immediate return to reset values; pending responses are not tracked.
// TESTING
//  1. Reset then pc=0x8000_0000 valid, rsp instr=0x0000_0013 next cycle
//     -> f2_ready low 1 cycle; f2_to_d_valid high with pc 0x8000_0000 / instr 0x13 the cycle after.
//  2. READY with f2_stall high 3 cycles -> pc/instr/valid stable; after stall drops, consumed; state EMPTY.
//  3. Capture pc 0x100, flush in WAIT, capture pc 0x104; responses 0xAAAA then 0xBBBB
//     -> 0xAAAA discarded, decode sees pc 0x104 / instr 0xBBBB.
//  4. Flush in WAIT on the same cycle the response arrives -> response dropped, drop_cnt stays 0, no output.
//  5. rsp_fault=1 with instr 0xDEAD -> f2_to_d_fault=1, instr=0. Also pc=0x102 -> f2_to_d_misalign=1, instr=0.
//  6. Back-to-back PCs 0x0,0x4,0x8 with 1-cycle IMSS latency, no stalls
//     -> three outputs in order, one every 2 cycles; async reset asserted mid-WAIT clears valid immediately.

Source files
------------

// File: rtl/letc_core_stage_fetch2_if.sv
// Fetch-2 boundary bundle: fetch 1 PC, IMSS response, decode output
// and adhesive stall/flush/ready, as seen by the stage (slave).
interface letc_core_stage_fetch2_if #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
);
    logic               f2_ready;
    logic               f2_flush;
    logic               f2_stall;
    logic               f1_to_f2_valid;
    logic [PC_W-1:0]    f1_to_f2_pc;
    logic               imss_rsp_valid;
    logic [INSTR_W-1:0] imss_rsp_instr;
    logic               imss_rsp_fault;
    logic               f2_to_d_valid;
    logic [PC_W-1:0]    f2_to_d_pc;
    logic [INSTR_W-1:0] f2_to_d_instr;
    logic               f2_to_d_fault;
    logic               f2_to_d_misalign;

    modport master (
        input  f2_ready,
        output f2_flush,
        output f2_stall,
        output f1_to_f2_valid,
        output f1_to_f2_pc,
        output imss_rsp_valid,
        output imss_rsp_instr,
        output imss_rsp_fault,
        input  f2_to_d_valid,
        input  f2_to_d_pc,
        input  f2_to_d_instr,
        input  f2_to_d_fault,
        input  f2_to_d_misalign
    );

    modport slave (
        output f2_ready,
        input  f2_flush,
        input  f2_stall,
        input  f1_to_f2_valid,
        input  f1_to_f2_pc,
        input  imss_rsp_valid,
        input  imss_rsp_instr,
        input  imss_rsp_fault,
        output f2_to_d_valid,
        output f2_to_d_pc,
        output f2_to_d_instr,
        output f2_to_d_fault,
        output f2_to_d_misalign
    );
endinterface

// File: rtl/letc_core_stage_fetch2.sv
// Fetch 2: pairs each fetch-1 PC with its in-order IMSS response and
// holds the pair for decode; drops responses orphaned by a flush.
module letc_core_stage_fetch2 #(
    parameter int PC_W     = 32,
    parameter int INSTR_W  = 32,
    parameter int MAX_DROP = 2
) (
    input logic clk,
    input logic rst_n,
    letc_core_stage_fetch2_if.slave f2
);
    localparam int DROP_W = $clog2(MAX_DROP + 1);
    localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);
    localparam logic [DROP_W-1:0] DROP_MAX = DROP_W'(MAX_DROP);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_WAIT,
        S_READY
    } state_t;

    state_t             state_q, state_d;
    logic [DROP_W-1:0]  drop_cnt, drop_cnt_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               fault_q, fault_d;

    logic rsp_use;
    logic drop_inc;
    logic drop_dec;
    logic misalign;

    assign rsp_use  = f2.imss_rsp_valid && (drop_cnt == '0);
    assign drop_dec = f2.imss_rsp_valid && (drop_cnt != '0);
    // A flush in WAIT orphans the pending response, unless it lands
    // in the flush cycle itself and is simply discarded right away.
    assign drop_inc = f2.f2_flush && (state_q == S_WAIT) && !rsp_use;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_EMPTY;
            drop_cnt <= '0;
            pc_q     <= '0;
            instr_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            drop_cnt <= drop_cnt_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            fault_q  <= fault_d;
        end
    end

    always_comb begin
        drop_cnt_d = drop_cnt;
        unique case ({drop_inc, drop_dec})
            2'b10:   drop_cnt_d = drop_cnt + DROP_ONE;
            2'b01:   drop_cnt_d = drop_cnt - DROP_ONE;
            default: drop_cnt_d = drop_cnt;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        fault_d = fault_q;
        if (f2.f2_flush) begin
            state_d = S_EMPTY;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (f2.f1_to_f2_valid) begin
                        pc_d    = f2.f1_to_f2_pc;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Latch regardless of stall; the hold happens in READY.
                    if (rsp_use) begin
                        instr_d = f2.imss_rsp_instr;
                        fault_d = f2.imss_rsp_fault;
                        state_d = S_READY;
                    end
                end
                S_READY: begin
                    if (!f2.f2_stall) begin
                        if (f2.f1_to_f2_valid) begin
                            pc_d    = f2.f1_to_f2_pc;
                            state_d = S_WAIT;
                        end else begin
                            state_d = S_EMPTY;
                        end
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    assign misalign            = (pc_q[1:0] != 2'b00);
    assign f2.f2_ready         = (state_q != S_WAIT);
    assign f2.f2_to_d_valid    = (state_q == S_READY) && !f2.f2_flush;
    assign f2.f2_to_d_pc       = pc_q;
    assign f2.f2_to_d_fault    = fault_q;
    assign f2.f2_to_d_misalign = misalign;
    assign f2.f2_to_d_instr    = (fault_q || misalign) ? '0 : instr_q;

    a_f1_valid_ok: assert property (
        @(posedge clk) disable iff (!rst_n)
        f2.f1_to_f2_valid |->
            (state_q == S_EMPTY) ||
            ((state_q == S_READY) && !f2.f2_stall)
    );

    a_drop_max: assert property (
        @(posedge clk) disable iff (!rst_n)
        drop_cnt <= DROP_MAX
    );

    a_rsp_only_wait: assert property (
        @(posedge clk) disable iff (!rst_n)
        (f2.imss_rsp_valid && (drop_cnt == '0)) |-> (state_q == S_WAIT)
    );

    a_no_flush_stall: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(f2.f2_flush && f2.f2_stall)
    );

    a_stall_stable: assert property (
        @(posedge clk) disable iff (!rst_n)
        ((state_q == S_READY) && f2.f2_stall) |=>
            ($stable(f2.f2_to_d_pc) && $stable(f2.f2_to_d_instr) &&
             $stable(f2.f2_to_d_fault) && $stable(f2.f2_to_d_misalign))
    );
endmodule

// File: tb/tb_letc_core_stage_fetch2.sv
// Scoreboard bench for fetch 2: directed PC/response sequences with
// hand-computed expected decode pairs checked by a separate monitor.
module tb_letc_core_stage_fetch2;
    logic clk;
    logic rst_n;

    letc_core_stage_fetch2_if #(.PC_W(32), .INSTR_W(32)) bus ();

    letc_core_stage_fetch2 #(
        .PC_W(32),
        .INSTR_W(32),
        .MAX_DROP(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .f2   (bus.slave)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
        logic        misalign;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.f2_flush       = 1'b0;
        bus.f2_stall       = 1'b0;
        bus.f1_to_f2_valid = 1'b0;
        bus.f1_to_f2_pc    = '0;
        bus.imss_rsp_valid = 1'b0;
        bus.imss_rsp_instr = '0;
        bus.imss_rsp_fault = 1'b0;
    endtask

    // Full EMPTY -> WAIT -> READY -> consumed round trip
    task automatic pair(input logic [31:0] pc, input logic [31:0] instr,
                        input logic fault, input exp_t e);
        exp_q.push_back(e);
        bus.f1_to_f2_valid = 1'b1;
        bus.f1_to_f2_pc    = pc;
        tick();
        bus.f1_to_f2_valid = 1'b0;
        bus.imss_rsp_valid = 1'b1;
        bus.imss_rsp_instr = instr;
        bus.imss_rsp_fault = fault;
        tick();
        bus.imss_rsp_valid = 1'b0;
        bus.imss_rsp_fault = 1'b0;
        tick();
    endtask

    // Monitor: compares every pair decode actually consumes
    always @(negedge clk) begin
        if (rst_n && bus.f2_to_d_valid && !bus.f2_stall) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out: got pc 0x%08h, expected none",
                         bus.f2_to_d_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_pc", bus.f2_to_d_pc, e.pc);
                chk("sb_instr", bus.f2_to_d_instr, e.instr);
                chk("sb_fault", 32'(bus.f2_to_d_fault), 32'(e.fault));
                chk("sb_misalign", 32'(bus.f2_to_d_misalign),
                    32'(e.misalign));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle_inputs();
        rst_n = 1'b0;
        #12;
        chk("rst_ready", 32'(bus.f2_ready), 32'd1);
        chk("rst_valid", 32'(bus.f2_to_d_valid), 32'd0);
        chk("rst_pc", bus.f2_to_d_pc, 32'd0);
        chk("rst_instr", bus.f2_to_d_instr, 32'd0);
        chk("rst_fault", 32'(bus.f2_to_d_fault), 32'd0);
        chk("rst_misalign", 32'(bus.f2_to_d_misalign), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: basic pair
        exp_q.push_back('{32'h8000_0000, 32'h0000_0013, 1'b0, 1'b0});
        bus.f1_to_f2_valid = 1'b1;
        bus.f1_to_f2_pc    = 32'h8000_0000;
        tick();
        bus.f1_to_f2_valid = 1'b0;
        chk("t1_ready_low", 32'(bus.f2_ready), 32'd0);
        chk("t1_valid_wait", 32'(bus.f2_to_d_valid), 32'd0);
        bus.imss_rsp_valid = 1'b1;
        bus.imss_rsp_instr = 32'h0000_0013;
        tick();
        bus.imss_rsp_valid = 1'b0;
        chk("t1_ready_back", 32'(bus.f2_ready), 32'd1);
        chk("t1_valid", 32'(bus.f2_to_d_valid), 32'd1);
        tick();
        chk("t1_empty", 32'(bus.f2_to_d_valid), 32'd0);

        // 2: stall holds outputs
        exp_q.push_back('{32'h0000_0200, 32'h1234_5678, 1'b0, 1'b0});
        bus.f1_to_f2_valid = 1'b1;
        bus.f1_to_f2_pc    = 32'h0000_0200;
        tick();
        bus.f1_to_f2_valid = 1'b0;
        bus.imss_rsp_valid = 1'b1;
        bus.imss_rsp_instr = 32'h1234_5678;
        tick();
        bus.imss_rsp_valid = 1'b0;
        bus.f2_stall       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t2_stall_valid", 32'(bus.f2_to_d_valid), 32'd1);
            chk("t2_stall_pc", bus.f2_to_d_pc, 32'h0000_0200);
            chk("t2_stall_instr", bus.f2_to_d_instr, 32'h1234_5678);
            tick();
        end
        bus.f2_stall = 1'b0;
        tick();
        chk("t2_empty_valid", 32'(bus.f2_to_d_valid), 32'd0);
        chk("t2_empty_ready", 32'(bus.f2_ready), 32'd1);

        // 3: flush in WAIT, orphan 0xAAAA dropped
        bus.f1_to_f2_valid = 1'b1;
        bus.f1_to_f2_pc    = 32'h0000_0100;
        tick();
        bus.f1_to_f2_valid = 1'b0;
        bus.f2_flush       = 1'b1;
        tick();
        bus.f2_flush = 1'b0;
        chk("t3_drop_one", 32'(dut.drop_cnt), 32'd1);
        exp_q.push_back('{32'h0000_0104, 32'h0000_BBBB, 1'b0, 1'b0});
        bus.f1_to_f2_valid = 1'b1;
        bus.f1_to_f2_pc    = 32'h0000_0104;
        bus.imss_rsp_valid = 1'b1;
        bus.imss_rsp_instr = 32'h0000_AAAA;
        tick();
        bus.f1_to_f2_valid = 1'b0;
        chk("t3_drop_zero", 32'(dut.drop_cnt), 32'd0);
        bus.imss_rsp_instr = 32'h0000_BBBB;
        tick();
        bus.imss_rsp_valid = 1'b0;
        chk("t3_valid", 32'(bus.f2_to_d_valid), 32'd1);
        tick();

        // 4: flush in WAIT with same-cycle response
        bus.f1_to_f2_valid = 1'b1;
        bus.f1_to_f2_pc    = 32'h0000_0300;
        tick();
        bus.f1_to_f2_valid = 1'b0;
        bus.f2_flush       = 1'b1;
        bus.imss_rsp_valid = 1'b1;
        bus.imss_rsp_instr = 32'h0000_5555;
        tick();
        idle_inputs();
        chk("t4_drop", 32'(dut.drop_cnt), 32'd0);
        chk("t4_valid", 32'(bus.f2_to_d_valid), 32'd0);
        chk("t4_ready", 32'(bus.f2_ready), 32'd1);
        tick();
        tick();

        // 5: fault and misalign both zero the instruction
        pair(32'h0000_0400, 32'h0000_DEAD, 1'b1,
             '{32'h0000_0400, 32'h0000_0000, 1'b1, 1'b0});
        pair(32'h0000_0102, 32'h0000_BEEF, 1'b0,
             '{32'h0000_0102, 32'h0000_0000, 1'b0, 1'b1});
        pair(32'h0000_0500, 32'h0000_BEEF, 1'b0,
             '{32'h0000_0500, 32'h0000_BEEF, 1'b0, 1'b0});

        // 6: back-to-back, one instr every 2 cycles
        for (int i = 0; i < 3; i++) begin
            logic [31:0] pcs [3];
            logic [31:0] ins [3];
            pcs = '{32'h0, 32'h4, 32'h8};
            ins = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113};
            exp_q.push_back('{pcs[i], ins[i], 1'b0, 1'b0});
            bus.f1_to_f2_valid = 1'b1;
            bus.f1_to_f2_pc    = pcs[i];
            tick();
            bus.f1_to_f2_valid = 1'b0;
            chk("t6_wait_valid", 32'(bus.f2_to_d_valid), 32'd0);
            bus.imss_rsp_valid = 1'b1;
            bus.imss_rsp_instr = ins[i];
            tick();
            bus.imss_rsp_valid = 1'b0;
            chk("t6_ready_valid", 32'(bus.f2_to_d_valid), 32'd1);
        end
        // READY pc 0x8 consumed alongside next PC 0xC
        bus.f1_to_f2_valid = 1'b1;
        bus.f1_to_f2_pc    = 32'h0000_000C;
        tick();
        bus.f1_to_f2_valid = 1'b0;
        chk("t6_c_wait", 32'(bus.f2_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(bus.f2_to_d_valid), 32'd0);
        chk("t6_rst_ready", 32'(bus.f2_ready), 32'd1);
        chk("t6_rst_pc", bus.f2_to_d_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk("end_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
